// File: rtl/multicycle_main_fsm.sv
// Main control unit of the multicycle RV32I/RV64I core: sequences fetch, decode,
// execute, memory and writeback over the shared ALU and memory port.
module multicycle_main_fsm #(
   parameter int unsigned XLEN          = 32,
   parameter bit          HALT_ON_ECALL = 1'b1,
   parameter int unsigned MEM_TIMEOUT   = 0,
   parameter int unsigned TW            = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [6:0] op_i,
   input  logic       mem_ready_i,
   output logic       mem_req_o,
   output logic       adr_src_o,
   output logic       ir_write_o,
   output logic       pc_write_o,
   output logic       branch_o,
   output logic       reg_write_o,
   output logic       mem_write_o,
   output logic [1:0] alu_src_a_o,
   output logic [1:0] alu_src_b_o,
   output logic [1:0] alu_op_o,
   output logic [1:0] result_src_o,
   output logic [2:0] imm_src_o,
   output logic       word_32_o,
   output logic       instr_done_o,
   output logic       halt_o,
   output logic       illegal_o,
   output logic       bus_err_o,
   output logic [3:0] state_o
);

   localparam logic [6:0] OP_LOAD    = 7'b0000011;
   localparam logic [6:0] OP_STORE   = 7'b0100011;
   localparam logic [6:0] OP_R       = 7'b0110011;
   localparam logic [6:0] OP_R_W     = 7'b0111011;
   localparam logic [6:0] OP_I_ALU   = 7'b0010011;
   localparam logic [6:0] OP_I_ALU_W = 7'b0011011;
   localparam logic [6:0] OP_B       = 7'b1100011;
   localparam logic [6:0] OP_JAL     = 7'b1101111;
   localparam logic [6:0] OP_JALR    = 7'b1100111;
   localparam logic [6:0] OP_LUI     = 7'b0110111;
   localparam logic [6:0] OP_AUIPC   = 7'b0010111;
   localparam logic [6:0] OP_ECALL   = 7'b1110011;

   localparam bit          RV64    = (XLEN == 64);
   localparam bit          TO_EN   = (MEM_TIMEOUT > 0);
   localparam logic [TW-1:0] TO_LAST = TW'(TO_EN ? MEM_TIMEOUT - 1 : 0);

   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_MEMADR    = 4'd2,
      S_MEMREAD   = 4'd3,
      S_MEMWB     = 4'd4,
      S_MEMWRITE  = 4'd5,
      S_EXECR     = 4'd6,
      S_EXECI     = 4'd7,
      S_EXECLUI   = 4'd8,
      S_EXECAUIPC = 4'd9,
      S_EXECJALR  = 4'd10,
      S_JUMP      = 4'd11,
      S_ALUWB     = 4'd12,
      S_BRANCH    = 4'd13,
      S_HALT      = 4'd14
   } state_e;

   state_e        state_q, state_d;
   logic [TW-1:0] cnt_q, cnt_d;
   logic          halt_q, halt_d;
   logic          illegal_q, illegal_d;
   logic          bus_err_q, bus_err_d;

   logic          is_w_op;
   logic          timed_out;

   logic          mem_req, adr_src, ir_write, pc_write, branch;
   logic          reg_write, mem_write, instr_done;
   logic [1:0]    alu_a, alu_b, alu_op, result_src;

   assign is_w_op   = (op_i == OP_R_W) || (op_i == OP_I_ALU_W);
   assign timed_out = TO_EN && !mem_ready_i && (cnt_q == TO_LAST);

   // State, wait counter and sticky status flags
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= S_FETCH;
         cnt_q     <= '0;
         halt_q    <= 1'b0;
         illegal_q <= 1'b0;
         bus_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         halt_q    <= halt_d;
         illegal_q <= illegal_d;
         bus_err_q <= bus_err_d;
      end
   end

   // Next state and per-state control; fetch and store completion are ready-qualified
   always_comb begin
      state_d    = state_q;
      cnt_d      = '0;
      illegal_d  = illegal_q;
      bus_err_d  = bus_err_q;
      mem_req    = 1'b0;
      adr_src    = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      branch     = 1'b0;
      reg_write  = 1'b0;
      mem_write  = 1'b0;
      instr_done = 1'b0;
      alu_a      = 2'b00;
      alu_b      = 2'b00;
      alu_op     = 2'b00;
      result_src = 2'b00;

      case (state_q)
         S_FETCH: begin
            mem_req    = 1'b1;
            alu_b      = 2'b10;
            result_src = 2'b10;
            if (mem_ready_i) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               state_d  = S_DECODE;
            end else if (timed_out) begin
               bus_err_d = 1'b1;
               state_d   = S_HALT;
            end else begin
               cnt_d = cnt_q + TW'(1);
            end
         end

         S_DECODE: begin
            alu_a = 2'b01;
            alu_b = 2'b01;
            case (op_i)
               OP_LOAD, OP_STORE: state_d = S_MEMADR;
               OP_R:              state_d = S_EXECR;
               OP_I_ALU:          state_d = S_EXECI;
               OP_B:              state_d = S_BRANCH;
               OP_JAL:            state_d = S_JUMP;
               OP_JALR:           state_d = S_EXECJALR;
               OP_LUI:            state_d = S_EXECLUI;
               OP_AUIPC:          state_d = S_EXECAUIPC;
               OP_R_W, OP_I_ALU_W: begin
                  if (RV64) begin
                     state_d = (op_i == OP_R_W) ? S_EXECR : S_EXECI;
                  end else begin
                     illegal_d = 1'b1;
                     state_d   = S_HALT;
                  end
               end
               OP_ECALL: begin
                  if (HALT_ON_ECALL) begin
                     state_d = S_HALT;
                  end else begin
                     instr_done = 1'b1;
                     state_d    = S_FETCH;
                  end
               end
               default: begin
                  illegal_d = 1'b1;
                  state_d   = S_HALT;
               end
            endcase
         end

         S_MEMADR: begin
            alu_a   = 2'b10;
            alu_b   = 2'b01;
            state_d = (op_i == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
         end

         S_MEMREAD: begin
            mem_req = 1'b1;
            adr_src = 1'b1;
            if (mem_ready_i) begin
               state_d = S_MEMWB;
            end else if (timed_out) begin
               bus_err_d = 1'b1;
               state_d   = S_HALT;
            end else begin
               cnt_d = cnt_q + TW'(1);
            end
         end

         S_MEMWB: begin
            result_src = 2'b01;
            reg_write  = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end

         S_MEMWRITE: begin
            mem_req   = 1'b1;
            adr_src   = 1'b1;
            mem_write = 1'b1;
            if (mem_ready_i) begin
               instr_done = 1'b1;
               state_d    = S_FETCH;
            end else if (timed_out) begin
               bus_err_d = 1'b1;
               state_d   = S_HALT;
            end else begin
               cnt_d = cnt_q + TW'(1);
            end
         end

         S_EXECR: begin
            alu_a   = 2'b10;
            alu_b   = 2'b00;
            alu_op  = 2'b10;
            state_d = S_ALUWB;
         end

         S_EXECI: begin
            alu_a   = 2'b10;
            alu_b   = 2'b01;
            alu_op  = 2'b10;
            state_d = S_ALUWB;
         end

         S_EXECLUI: begin
            alu_a   = 2'b11;
            alu_b   = 2'b01;
            state_d = S_ALUWB;
         end

         S_EXECAUIPC: begin
            alu_a   = 2'b01;
            alu_b   = 2'b01;
            state_d = S_ALUWB;
         end

         S_EXECJALR: begin
            alu_a   = 2'b10;
            alu_b   = 2'b01;
            state_d = S_JUMP;
         end

         // PC takes the target held in ALUOut while the ALU forms the link address
         S_JUMP: begin
            alu_a    = 2'b01;
            alu_b    = 2'b10;
            pc_write = 1'b1;
            state_d  = S_ALUWB;
         end

         S_ALUWB: begin
            reg_write  = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end

         S_BRANCH: begin
            alu_a      = 2'b10;
            alu_b      = 2'b00;
            alu_op     = 2'b01;
            branch     = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end

         S_HALT: begin
            state_d = S_HALT;
         end

         default: begin
            state_d = S_FETCH;
         end
      endcase

      halt_d = halt_q || (state_d == S_HALT);
   end

   // Immediate format follows the opcode regardless of state
   always_comb begin
      imm_src_o = 3'b000;
      case (op_i)
         OP_STORE:          imm_src_o = 3'b001;
         OP_B:              imm_src_o = 3'b010;
         OP_JAL:            imm_src_o = 3'b011;
         OP_LUI, OP_AUIPC:  imm_src_o = 3'b100;
         default:           imm_src_o = 3'b000;
      endcase
   end

   assign word_32_o = RV64 && is_w_op;

   // Reset forces every enable and select low without waiting for a clock edge
   assign mem_req_o    = mem_req    && !rst_i;
   assign adr_src_o    = adr_src    && !rst_i;
   assign ir_write_o   = ir_write   && !rst_i;
   assign pc_write_o   = pc_write   && !rst_i;
   assign branch_o     = branch     && !rst_i;
   assign reg_write_o  = reg_write  && !rst_i;
   assign mem_write_o  = mem_write  && !rst_i;
   assign instr_done_o = instr_done && !rst_i;
   assign alu_src_a_o  = rst_i ? 2'b00 : alu_a;
   assign alu_src_b_o  = rst_i ? 2'b00 : alu_b;
   assign alu_op_o     = rst_i ? 2'b00 : alu_op;
   assign result_src_o = rst_i ? 2'b00 : result_src;

   assign halt_o    = halt_q;
   assign illegal_o = illegal_q;
   assign bus_err_o = bus_err_q;
   assign state_o   = state_q;

endmodule
